// File: rtl/modulo_ctrl_botoes_pkg.sv
// Shared constants for the button control stage: button polarity and debounce defaults.
package modulo_ctrl_botoes_pkg;
  localparam logic BTN_PRESSED    = 1'b0;
  localparam logic BTN_RELEASED   = 1'b1;
  localparam int   DEBOUNCE_SYNTH = 50000;
  localparam int   DEBOUNCE_SIM   = 4;
endpackage

// File: rtl/modulo_ctrl_botoes_if.sv
// Raw buttons in, command strobes out; master drives buttons, slave is the control stage.
interface modulo_ctrl_botoes_if #(parameter int N_BTN = 4);
  logic [N_BTN-1:0] btn_t;
  logic             btn_clr;
  logic             btn_prst;
  logic [N_BTN-1:0] t;
  logic             clr;
  logic             prst;
  logic             enable;

  modport master (output btn_t, btn_clr, btn_prst, input t, clr, prst, enable);
  modport slave  (input btn_t, btn_clr, btn_prst, output t, clr, prst, enable);
endinterface

// File: rtl/modulo_ctrl_botoes_debounce.sv
// One button: 2-flop synchronizer, stability counter, single-cycle press pulse on accepted 1->0.
module modulo_debounce
  import modulo_ctrl_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SYNTH
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta, s, stable;
  logic [CNT_W-1:0] cnt;

  // Any sample matching the accepted level restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta   <= BTN_RELEASED;
      s      <= BTN_RELEASED;
      stable <= BTN_RELEASED;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      meta  <= raw;
      s     <= meta;
      press <= 1'b0;
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s;
        cnt    <= '0;
        press  <= (s == BTN_PRESSED);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/modulo_ctrl_botoes.sv
// Debounces N_BTN toggle buttons plus clear/preset and issues prioritized one-cycle strobes.
module modulo_ctrl_botoes
  import modulo_ctrl_botoes_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SYNTH
) (
  input  logic                 clk,
  input  logic                 clr_n,
  modulo_ctrl_botoes_if.slave  bus
);
  logic [N_BTN+1:0] raw, press;
  logic [N_BTN-1:0] t_nxt;
  logic             clr_nxt, prst_nxt;

  assign raw = {bus.btn_prst, bus.btn_clr, bus.btn_t};

  for (genvar i = 0; i < N_BTN + 2; i++) begin : g_db
    modulo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .clr_n (clr_n),
      .raw   (raw[i]),
      .press (press[i])
    );
  end

  // clr > prst > t; losing presses are dropped, not held for later.
  always_comb begin
    t_nxt    = '0;
    clr_nxt  = 1'b0;
    prst_nxt = 1'b0;
    if (press[N_BTN])          clr_nxt  = 1'b1;
    else if (press[N_BTN+1])   prst_nxt = 1'b1;
    else                       t_nxt    = press[N_BTN-1:0];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus.t      <= '0;
      bus.clr    <= 1'b0;
      bus.prst   <= 1'b0;
      bus.enable <= 1'b0;
    end else begin
      bus.t      <= t_nxt;
      bus.clr    <= clr_nxt;
      bus.prst   <= prst_nxt;
      bus.enable <= clr_nxt | prst_nxt | (|t_nxt);
    end
  end
endmodule

// File: tb/tb_modulo_ctrl_botoes.sv
// Directed bench: vector table of single presses plus bounce, reset and T-flip-flop integration sequences.
module tb_modulo_ctrl_botoes;
  import modulo_ctrl_botoes_pkg::*;

  logic clk = 1'b0;
  logic clr_n;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] q;

  modulo_ctrl_botoes_if #(.N_BTN(4)) bus ();

  modulo_ctrl_botoes #(.N_BTN(4), .DEBOUNCE_CYCLES(DEBOUNCE_SIM)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Downstream T flip-flop bank capturing on the falling edge.
  always @(negedge clk) begin
    if (bus.clr)       q <= 4'b0000;
    else if (bus.prst) q <= 4'b1111;
    else               q <= q ^ bus.t;
  end

  typedef struct {
    string      name;
    logic [3:0] bt;
    logic       bc;
    logic       bp;
    logic [3:0] et;
    logic       ec;
    logic       ep;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [6:0] outs();
    return {bus.t, bus.clr, bus.prst, bus.enable};
  endfunction

  function automatic logic [6:0] mk(input logic [3:0] et, input logic ec, input logic ep);
    return {et, ec, ep, (|et) | ec | ep};
  endfunction

  task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", nm, got, exp);
    end
  endtask

  // Drive a button pattern at a falling edge, then check every following rising edge;
  // cycle 0 is the first edge that samples the pattern.
  task automatic apply(input string nm, input logic [3:0] bt, input logic bc, input logic bp,
                       input int n, input int off, input logic [6:0] ev);
    @(negedge clk);
    bus.btn_t    = bt;
    bus.btn_clr  = bc;
    bus.btn_prst = bp;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      chk(nm, outs(), (c == off) ? ev : 7'd0);
    end
  endtask

  task automatic press(input string nm, input logic [3:0] bt, input logic bc, input logic bp,
                       input logic [6:0] ev);
    apply(nm, bt, bc, bp, 20, 6, ev);
    apply({nm, "_rel"}, 4'hF, 1'b1, 1'b1, 12, -1, 7'd0);
  endtask

  initial begin
    vecs[0] = '{"clean_t2",   4'b1011, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0};
    vecs[1] = '{"multi_t30",  4'b0110, 1'b1, 1'b1, 4'b1001, 1'b0, 1'b0};
    vecs[2] = '{"prio_clr",   4'b1101, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[3] = '{"prio_prst",  4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[4] = '{"all_t",      4'b0000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[5] = '{"clr_only",   4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0};

    clr_n        = 1'b0;
    bus.btn_t    = 4'hF;
    bus.btn_clr  = 1'b1;
    bus.btn_prst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", outs(), 7'd0);
    @(negedge clk);
    clr_n = 1'b1;
    apply("idle", 4'hF, 1'b1, 1'b1, 8, -1, 7'd0);

    for (int i = 0; i < 6; i++)
      press(vecs[i].name, vecs[i].bt, vecs[i].bc, vecs[i].bp,
            mk(vecs[i].et, vecs[i].ec, vecs[i].ep));

    // Bounce: two 3-sample lows separated by a high never reach the threshold.
    apply("bounce_a", 4'b1110, 1'b1, 1'b1, 3, -1, 7'd0);
    apply("bounce_b", 4'b1111, 1'b1, 1'b1, 1, -1, 7'd0);
    apply("bounce_c", 4'b1110, 1'b1, 1'b1, 3, -1, 7'd0);
    apply("bounce_d", 4'b1111, 1'b1, 1'b1, 12, -1, 7'd0);
    apply("bounce_hold", 4'b1110, 1'b1, 1'b1, 10, 6, mk(4'b0001, 1'b0, 1'b0));
    apply("bounce_rel", 4'hF, 1'b1, 1'b1, 12, -1, 7'd0);

    // Reset mid-debounce with preset held: outputs stay low, one strobe after re-detection.
    apply("rst_pre", 4'hF, 1'b1, 1'b0, 4, -1, 7'd0);
    @(negedge clk);
    clr_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_hold", outs(), 7'd0);
    end
    clr_n = 1'b1;
    apply("rst_post", 4'hF, 1'b1, 1'b0, 14, 6, mk(4'b0000, 1'b0, 1'b1));
    apply("rst_rel", 4'hF, 1'b1, 1'b1, 12, -1, 7'd0);

    // Reset landing on a live strobe clears it immediately; nothing follows once released.
    apply("mid_strobe", 4'b0111, 1'b1, 1'b1, 7, 6, mk(4'b1000, 1'b0, 1'b0));
    #2 clr_n = 1'b0;
    bus.btn_t = 4'hF;
    #1 chk("mid_strobe_abort", outs(), 7'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    apply("mid_strobe_after", 4'hF, 1'b1, 1'b1, 12, -1, 7'd0);

    // Integration with the T flip-flop bank.
    press("int_clr", 4'hF, 1'b0, 1'b1, mk(4'b0000, 1'b1, 1'b0));
    chk("q_after_clr", {3'b0, q}, 7'b0000000);
    press("int_t1_a", 4'b1101, 1'b1, 1'b1, mk(4'b0010, 1'b0, 1'b0));
    chk("q1_first", {6'b0, q[1]}, 7'd1);
    press("int_t1_b", 4'b1101, 1'b1, 1'b1, mk(4'b0010, 1'b0, 1'b0));
    chk("q1_second", {6'b0, q[1]}, 7'd0);
    press("int_t1_c", 4'b1101, 1'b1, 1'b1, mk(4'b0010, 1'b0, 1'b0));
    chk("q1_third", {6'b0, q[1]}, 7'd1);
    press("int_prst", 4'hF, 1'b1, 1'b0, mk(4'b0000, 1'b0, 1'b1));
    chk("q_after_prst", {3'b0, q}, 7'b0001111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
